// File: rtl/issue_arb_pkg.sv
// Shared constants and sizing helpers for the issue-stage round-robin arbiter.
package issue_arb_pkg;

  localparam int MAX_ARB_REQ = 64;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Pointer/index width for n requesters; never narrower than one bit.
  function automatic int ptr_w(input int n);
    return (n <= 2) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/issue_rr_rotate_arbiter_rotate.sv
// Combinational circular rotator of arbitrary width (no power-of-two padding).
// DIR=0 rotates right, DIR=1 rotates left; shamt is assumed to be < WIDTH.
module circular_rotate_nb #(
  parameter int WIDTH   = 8,
  parameter int SHAMT_W = 3,
  parameter bit DIR     = 1'b0
) (
  input  logic [WIDTH-1:0]   din,
  input  logic [SHAMT_W-1:0] shamt,
  output logic [WIDTH-1:0]   dout
);

  for (genvar s = 0; s < SHAMT_W; s++) begin : g_stage
    // Stage weight is reduced modulo WIDTH so non-power-of-two widths wrap correctly.
    localparam int AMT = (1 << s) % WIDTH;
    localparam int SH  = DIR ? ((WIDTH - AMT) % WIDTH) : AMT;

    logic [WIDTH-1:0] src;
    logic [WIDTH-1:0] rot;
    logic [WIDTH-1:0] lvl;

    if (s == 0) begin : g_first
      assign src = din;
    end else begin : g_next
      assign src = g_stage[s-1].lvl;
    end

    if (SH == 0) begin : g_pass
      assign rot = src;
    end else begin : g_rot
      assign rot = {src[SH-1:0], src[WIDTH-1:SH]};
    end

    assign lvl = shamt[s] ? rot : src;
  end

  assign dout = g_stage[SHAMT_W-1].lvl;

endmodule

// File: rtl/issue_rr_rotate_arbiter.sv
// Round-robin issue arbiter: rotate req by the priority pointer, pick the lowest
// set bit, rotate the index back, and register the grant.
module issue_rr_rotate_arbiter
  import issue_arb_pkg::*;
#(
  parameter int NUM_REQ = 40,
  parameter int PTR_W   = ptr_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               arb_en,
  input  logic               ptr_ld,
  input  logic [PTR_W-1:0]   ptr_ld_val,
  output logic               grant_valid,
  output logic [NUM_REQ-1:0] grant_oh,
  output logic [PTR_W-1:0]   grant_id,
  output logic [PTR_W-1:0]   prio_ptr
);

  localparam logic [PTR_W:0] N_EXT = (PTR_W+1)'(NUM_REQ);

  logic [NUM_REQ-1:0] rot;
  logic [PTR_W-1:0]   k;
  logic [PTR_W:0]     sum;
  logic [PTR_W-1:0]   win;
  logic [PTR_W:0]     win_inc;
  logic [PTR_W-1:0]   nxt_ptr;
  logic [PTR_W-1:0]   ld_ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [NUM_REQ-1:0] gid_oh;

  circular_rotate_nb #(
    .WIDTH   (NUM_REQ),
    .SHAMT_W (PTR_W),
    .DIR     (1'b0)
  ) u_rot (
    .din   (req),
    .shamt (prio_ptr),
    .dout  (rot)
  );

  always_comb begin
    k = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (rot[i]) k = PTR_W'(i);
  end

  // Modulo add back into the unrotated index space; one subtract suffices since both terms < NUM_REQ.
  assign sum     = {1'b0, prio_ptr} + {1'b0, k};
  assign win     = (sum >= N_EXT) ? PTR_W'(sum - N_EXT) : PTR_W'(sum);
  assign win_inc = {1'b0, win} + (PTR_W+1)'(1);
  assign nxt_ptr = (win_inc >= N_EXT) ? '0 : win_inc[PTR_W-1:0];
  assign ld_ptr  = ({1'b0, ptr_ld_val} >= N_EXT) ? '0 : ptr_ld_val;

  always_comb begin
    win_oh = '0;
    gid_oh = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      win_oh[i] = (win == PTR_W'(i));
      gid_oh[i] = (grant_id == PTR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_valid <= 1'b0;
      grant_oh    <= '0;
      grant_id    <= '0;
      prio_ptr    <= '0;
    end else begin
      grant_valid <= 1'b0;
      grant_oh    <= '0;
      if (arb_en && (|req)) begin
        grant_valid <= 1'b1;
        grant_oh    <= win_oh;
        grant_id    <= win;
        prio_ptr    <= nxt_ptr;
      end
      // A load wins over the advance; this cycle's grant already used the old pointer.
      if (ptr_ld) prio_ptr <= ld_ptr;
    end
  end

  a_oh_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant_oh));
  a_oh_vs_valid : assert property (@(posedge clk) disable iff (!rst_n)
    ((grant_oh != '0) == grant_valid));
  a_oh_vs_id : assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid |-> (grant_oh == gid_oh));
  a_granted_req : assert property (@(posedge clk) disable iff (!rst_n)
    grant_valid |-> ((grant_oh & $past(req)) != '0));
  a_ptr_range : assert property (@(posedge clk) disable iff (!rst_n)
    ({1'b0, prio_ptr} < N_EXT));

endmodule

// File: tb/tb_issue_rr_rotate_arbiter.sv
// Bench for issue_rr_rotate_arbiter: an 8-wide and a 40-wide instance checked
// against a linear-search round-robin model through per-instance scoreboards.
module tb_issue_rr_rotate_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [7:0]  r8;  logic en8,  ld8;  logic [3:0] ldv8;
  logic        gv8; logic [7:0]  oh8;  logic [3:0] gid8,  ptr8;
  logic [39:0] r40; logic en40, ld40; logic [5:0] ldv40;
  logic        gv40; logic [39:0] oh40; logic [5:0] gid40, ptr40;

  issue_rr_rotate_arbiter #(.NUM_REQ(8), .PTR_W(4)) u8 (
    .clk(clk), .rst_n(rst_n), .req(r8), .arb_en(en8), .ptr_ld(ld8), .ptr_ld_val(ldv8),
    .grant_valid(gv8), .grant_oh(oh8), .grant_id(gid8), .prio_ptr(ptr8));

  issue_rr_rotate_arbiter #(.NUM_REQ(40)) u40 (
    .clk(clk), .rst_n(rst_n), .req(r40), .arb_en(en40), .ptr_ld(ld40), .ptr_ld_val(ldv40),
    .grant_valid(gv40), .grant_oh(oh40), .grant_id(gid40), .prio_ptr(ptr40));

  typedef struct {
    logic        gv;
    logic [63:0] oh;
    logic [6:0]  gid;
    logic [6:0]  ptr;
  } exp_t;

  exp_t q8[$];
  exp_t q40[$];
  int   m_ptr[2];
  int   m_gid[2];
  int   checks = 0;
  int   passed = 0;

  task automatic model_reset();
    m_ptr[0] = 0; m_ptr[1] = 0; m_gid[0] = 0; m_gid[1] = 0;
    q8.delete(); q40.delete();
  endtask

  // Reference: scan upward from the pointer, wrapping modulo n.
  task automatic model_push(input int u, input logic [63:0] req, input logic en, input logic ld,
                            input int ldv, output exp_t e);
    int n;
    int win;
    n = (u == 0) ? 8 : 40;
    win = -1;
    e.gv = 1'b0;
    e.oh = '0;
    if (en)
      for (int j = 0; j < n; j++) begin
        int idx;
        idx = (m_ptr[u] + j) % n;
        if (req[idx] && win < 0) win = idx;
      end
    if (win >= 0) begin
      e.gv = 1'b1;
      e.oh = 64'd1 << win;
      m_gid[u] = win;
      m_ptr[u] = (win + 1) % n;
    end
    if (ld) m_ptr[u] = (ldv >= n) ? 0 : ldv;
    e.gid = 7'(m_gid[u]);
    e.ptr = 7'(m_ptr[u]);
    if (u == 0) q8.push_back(e); else q40.push_back(e);
  endtask

  task automatic drive8(input logic [7:0] r, input logic en, input logic ld, input int ldv);
    exp_t e;
    r8 = r; en8 = en; ld8 = ld; ldv8 = 4'(ldv);
    model_push(0, {56'b0, r}, en, ld, ldv, e);
    @(posedge clk); #1;
  endtask

  task automatic drive40(input logic [39:0] r, input logic en, input logic ld, input int ldv);
    exp_t e;
    r40 = r; en40 = en; ld40 = ld; ldv40 = 6'(ldv);
    model_push(1, {24'b0, r}, en, ld, ldv, e);
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0;
    r8 = '0; en8 = 0; ld8 = 0; ldv8 = '0;
    r40 = '0; en40 = 0; ld40 = 0; ldv40 = '0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      checks++;
      if ({gv8, oh8, gid8, ptr8, gv40, oh40, gid40, ptr40} !== '0)
        $display("FAIL reset_hold: u8 gv=%b oh=%h id=%0d ptr=%0d u40 gv=%b ptr=%0d, want all 0",
                 gv8, oh8, gid8, ptr8, gv40, ptr40);
      else passed++;
    end
    rst_n = 1'b1;
    repeat (3) begin
      drive8(8'h00, 1'b1, 1'b0, 0);
      checks++;
      e = q8.pop_front();
      if ({gv8, oh8, gid8, ptr8} !== {e.gv, e.oh[7:0], e.gid[3:0], e.ptr[3:0]})
        $display("FAIL reset_idle: gv=%b oh=%h id=%0d ptr=%0d, want gv=%b oh=%h id=%0d ptr=%0d",
                 gv8, oh8, gid8, ptr8, e.gv, e.oh[7:0], e.gid, e.ptr);
      else passed++;
    end
  endtask

  task automatic test_rotation();
    exp_t e;
    for (int i = 0; i < 10; i++) begin
      drive8(8'hFF, 1'b1, 1'b0, 0);
      checks++;
      e = q8.pop_front();
      if ({gv8, oh8, gid8, ptr8} !== {e.gv, e.oh[7:0], e.gid[3:0], e.ptr[3:0]})
        $display("FAIL rotation[%0d]: gv=%b oh=%h id=%0d ptr=%0d, want gv=%b oh=%h id=%0d ptr=%0d",
                 i, gv8, oh8, gid8, ptr8, e.gv, e.oh[7:0], e.gid, e.ptr);
      else passed++;
      checks++;
      if (gid8 !== 4'(i % 8) || ptr8 !== 4'((i + 1) % 8))
        $display("FAIL rotation_seq[%0d]: id=%0d ptr=%0d, want id=%0d ptr=%0d",
                 i, gid8, ptr8, i % 8, (i + 1) % 8);
      else passed++;
    end
  endtask

  task automatic test_stall();
    exp_t e;
    logic [7:0] sr[3]  = '{8'h10, 8'h10, 8'h00};
    logic       sen[3] = '{1'b0, 1'b1, 1'b1};
    int         sp[3]  = '{2, 5, 5};
    for (int i = 0; i < 3; i++) begin
      drive8(sr[i], sen[i], 1'b0, 0);
      checks++;
      e = q8.pop_front();
      if ({gv8, oh8, gid8, ptr8} !== {e.gv, e.oh[7:0], e.gid[3:0], e.ptr[3:0]} || ptr8 !== 4'(sp[i]))
        $display("FAIL stall[%0d]: gv=%b oh=%h id=%0d ptr=%0d, want gv=%b oh=%h id=%0d ptr=%0d",
                 i, gv8, oh8, gid8, ptr8, e.gv, e.oh[7:0], e.gid, sp[i]);
      else passed++;
    end
  endtask

  task automatic test_load_grant();
    exp_t e;
    logic [7:0] sr[3]  = '{8'h00, 8'h0C, 8'h00};
    logic       sen[3] = '{1'b0, 1'b1, 1'b0};
    int         sv[3]  = '{2, 6, 9};
    int         sp[3]  = '{2, 6, 0};
    for (int i = 0; i < 3; i++) begin
      drive8(sr[i], sen[i], 1'b1, sv[i]);
      checks++;
      e = q8.pop_front();
      if ({gv8, oh8, gid8, ptr8} !== {e.gv, e.oh[7:0], e.gid[3:0], e.ptr[3:0]} || ptr8 !== 4'(sp[i]))
        $display("FAIL load_grant[%0d]: gv=%b oh=%h id=%0d ptr=%0d, want gv=%b oh=%h id=%0d ptr=%0d",
                 i, gv8, oh8, gid8, ptr8, e.gv, e.oh[7:0], e.gid, sp[i]);
      else passed++;
    end
  endtask

  task automatic test_nonpow2_wrap();
    exp_t e;
    logic [39:0] two = '0;
    logic [39:0] sr[3];
    int          sp[3] = '{38, 0, 3};
    int          sg[3] = '{0, 39, 2};
    two[39] = 1'b1; two[2] = 1'b1;
    sr[0] = '0; sr[1] = two; sr[2] = two;
    for (int i = 0; i < 3; i++) begin
      drive40(sr[i], i != 0, i == 0, 38);
      checks++;
      e = q40.pop_front();
      if ({gv40, oh40, gid40, ptr40} !== {e.gv, e.oh[39:0], e.gid[5:0], e.ptr[5:0]} ||
          ptr40 !== 6'(sp[i]) || gid40 !== 6'(sg[i]))
        $display("FAIL nonpow2[%0d]: gv=%b oh=%h id=%0d ptr=%0d, want gv=%b oh=%h id=%0d ptr=%0d",
                 i, gv40, oh40, gid40, ptr40, e.gv, e.oh[39:0], sg[i], sp[i]);
      else passed++;
    end
    en40 = 1'b0; ld40 = 1'b0; r40 = '0;
  endtask

  task automatic test_async_reset_random();
    exp_t e8, e40, d;
    logic [7:0] pend;
    int         w[8];
    int         maxw;
    drive8(8'hFF, 1'b1, 1'b0, 0);
    checks++;
    d = q8.pop_front();
    if (gv8 !== 1'b1 || gv8 !== d.gv)
      $display("FAIL pre_reset_grant: gv=%b, want 1", gv8);
    else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({gv8, oh8, gid8, ptr8} !== '0)
      $display("FAIL async_reset: gv=%b oh=%h id=%0d ptr=%0d, want all 0", gv8, oh8, gid8, ptr8);
    else passed++;
    r8 = '0; en8 = 0; ld8 = 0; r40 = '0; en40 = 0; ld40 = 0;
    model_reset();
    @(negedge clk) rst_n = 1'b1;

    pend = '0;
    maxw = 0;
    foreach (w[i]) w[i] = 0;
    for (int c = 0; c < 10000; c++) begin
      pend |= 8'($urandom) & 8'($urandom);
      r8 = pend; en8 = ($urandom_range(0, 4) != 0); ld8 = 1'b0;
      r40 = 40'({$urandom, $urandom}) & 40'({$urandom, $urandom});
      en40 = ($urandom_range(0, 3) != 0);
      ld40 = ($urandom_range(0, 15) == 0);
      ldv40 = 6'($urandom_range(0, 63));
      model_push(0, {56'b0, r8}, en8, 1'b0, 0, e8);
      model_push(1, {24'b0, r40}, en40, ld40, int'(ldv40), e40);
      @(posedge clk); #1;
      e8 = q8.pop_front();
      e40 = q40.pop_front();
      checks++;
      if ({gv8, oh8, gid8, ptr8} !== {e8.gv, e8.oh[7:0], e8.gid[3:0], e8.ptr[3:0]}) begin
        if (checks - passed < 20)
          $display("FAIL random8[%0d]: gv=%b oh=%h id=%0d ptr=%0d, want gv=%b oh=%h id=%0d ptr=%0d",
                   c, gv8, oh8, gid8, ptr8, e8.gv, e8.oh[7:0], e8.gid, e8.ptr);
      end else passed++;
      checks++;
      if ({gv40, oh40, gid40, ptr40} !== {e40.gv, e40.oh[39:0], e40.gid[5:0], e40.ptr[5:0]}) begin
        if (checks - passed < 20)
          $display("FAIL random40[%0d]: gv=%b id=%0d ptr=%0d, want gv=%b id=%0d ptr=%0d",
                   c, gv40, gid40, ptr40, e40.gv, e40.gid, e40.ptr);
      end else passed++;
      // Requesters hold until granted; count arbitrating cycles spent waiting.
      for (int i = 0; i < 8; i++) begin
        if (en8 && pend[i]) w[i]++;
        if (e8.gv && e8.gid == 7'(i)) begin
          if (w[i] > maxw) maxw = w[i];
          w[i] = 0;
          pend[i] = 1'b0;
        end
      end
    end
    checks++;
    if (maxw > 8 || maxw == 0)
      $display("FAIL fairness: worst wait %0d arbitrating cycles, want 1..8", maxw);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stall();
    test_load_grant();
    test_nonpow2_wrap();
    test_async_reset_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d so far", passed, checks);
    $fatal(1);
  end

endmodule

// File: doc/issue_rr_rotate_arbiter.md
Name: issue_rr_rotate_arbiter

Overview:
- Parametrised round-robin arbiter for the issue stage; selects one of NUM_REQ ready wavefronts per cycle.
- Rotates the request vector by a rotating priority pointer (circular barrel shift) and takes the lowest set bit. The winner index is rotated back, and the grant is registered.
- Generalises the fixed 9-bit rotator to any width, including non-power-of-two widths. Adds pointer state, advance-on-grant, pointer load and a registered one-hot/encoded grant.

Parameters:
- NUM_REQ, 40, number of requesters (wavefront slots); legal range 2..64, any value including non-power-of-two.
- PTR_W, $clog2(NUM_REQ), width of the pointer and grant index.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  request vector; bit i means slot i is eligible this cycle.
- arb_en  in  1  downstream can accept a grant this cycle.
- ptr_ld  in  1  force the priority pointer (flush/restart).
- ptr_ld_val  in  PTR_W  value loaded when ptr_ld=1.
- grant_valid  out  1  registered; a grant was issued last arbitrating cycle.
- grant_oh  out  NUM_REQ  registered one-hot grant.
- grant_id  out  PTR_W  registered encoded grant index.
- prio_ptr  out  PTR_W  current highest-priority slot.

Behaviour:
- Reset (rst_n=0, asynchronous): prio_ptr=0, grant_valid=0, grant_oh=0, grant_id=0. Deassertion takes effect at the next clk edge. Reset mid-arbitration discards any in-flight grant.
- Combinational path each cycle:
  - rot = req rotated right by prio_ptr, modulo NUM_REQ. Bits that shift out re-enter at the top, so only NUM_REQ positions exist, with no power-of-two padding.
  - k = index of the lowest set bit of rot.
  - win = prio_ptr + k; if win >= NUM_REQ then win -= NUM_REQ.
- Registered update on clk rising edge, latency 1 cycle from req/arb_en to grant outputs:
  - arb_en=1 and req!=0: grant_valid<=1, grant_id<=win, grant_oh<=(1<<win), prio_ptr<=(win+1) mod NUM_REQ.
  - arb_en=1 and req==0: grant_valid<=0, grant_oh<=0, grant_id holds, prio_ptr holds.
  - arb_en=0: grant_valid<=0, grant_oh<=0, grant_id and prio_ptr hold; req is ignored.
  - ptr_ld=1: prio_ptr<=ptr_ld_val, overriding the advance above. The grant in that same cycle is still computed with the old prio_ptr.
  - ptr_ld_val >= NUM_REQ: prio_ptr<=0.
- Wrap-around: win=NUM_REQ-1 makes the next prio_ptr 0.
- Fairness: a continuously asserted request is granted within NUM_REQ arbitrating cycles.
- Invariants, checked by assertions:
  - grant_oh is one-hot or zero.
  - grant_oh==0 exactly when grant_valid==0.
  - When grant_valid=1, grant_oh equals 1<<grant_id.
  - The granted bit was set in req in the previous cycle.
  - prio_ptr < NUM_REQ always.

Decomposition:
- Shared package issue_arb_pkg:
  - localparam function clog2.
  - Pointer-width helper.
  - Constant MAX_ARB_REQ=64.
- Sub-module circular_rotate_nb:
  - Parametrised combinational rotator; parameters WIDTH and SHAMT_W, plus a DIR parameter (0=right, 1=left).
  - Log2 mux stages, with each stage's shift taken modulo WIDTH.
  - Instantiated once (right) for req.
- The top level holds the priority encoder, the modulo add, the registers and the assertions.

Test Plan:
- Reset: NUM_REQ=8, rst_n=0 then release, req=0 -> prio_ptr=0, grant_valid=0, grant_oh=0 for 3 cycles.
- Rotation: NUM_REQ=8, req=8'hFF, arb_en=1 held for 10 cycles -> grant_id sequence 0,1,...,7,0,1 and prio_ptr wraps 7->0.
- Non-power-of-two wrap: NUM_REQ=40, prio_ptr loaded to 38, req has bits {39,2} set -> grant_id 39 and then 2. prio_ptr goes 38 -> 0 after the first grant, then 3.
- Stall/empty: req=8'h10 with arb_en=0 -> grant_valid=0 and prio_ptr unchanged. Then arb_en=1 -> grant_id=4 next cycle and prio_ptr=5. Then req=0 -> grant_valid=0 and prio_ptr=5.
- Simultaneous load and grant: prio_ptr=2, req=8'h0C, ptr_ld=1, ptr_ld_val=6 -> grant_id=2 next cycle, prio_ptr=6 (not 3). Then ptr_ld_val=9 on NUM_REQ=8 -> prio_ptr=0.
- Async reset mid-operation: assert rst_n=0 between clock edges while grant_valid=1 -> outputs go to 0 immediately without waiting for clk. Random req for 10k cycles afterwards -> all invariants hold, and no continuously asserted requester waits more than 8 arbitrating cycles.
